core_wb_miss_master: RTL and testbench
======================================

# core_wb_miss_master

Wishbone bus initiator that services instruction- and data-cache line misses from `core_top` over the Caravel user-project Wishbone bus. It latches one pending miss per cache and arbitrates between them with fixed data-cache priority. Each 128-bit line moves as four 32-bit single-word Wishbone transfers. The block returns a one-cycle response on the existing `rsp_*_miss` interface.

## Interface
- `WB_BASE_ADDR`, default `32'h3000_0000`: byte base of the line-backed memory window.
- `TIMEOUT_CYCLES`, default `16`: maximum cycles to wait for ack/err on one beat. Used only with `WB_MISS_TIMEOUT_EN`.
- `clk_i`  in  1: single clock; all state is on the rising edge.
- `reset_ni`  in  1: asynchronous, active-low reset.
- `dcache_req_valid_miss`  in  1: one-cycle dcache miss strobe.
- `dcache_req_info_miss`  in  149: [148:129] line address, [128] write, [127:0] line data.
- `icache_req_valid_miss`  in  1: one-cycle icache miss strobe.
- `icache_req_info_miss`  in  149: same format as the dcache field.
- `rsp_valid_miss`  out  1: one-cycle response strobe.
- `rsp_data_miss`  out  128: line read data. Zero for writes and errors.
- `rsp_cache_id`  out  1: 1 = dcache, 0 = icache.
- `rsp_bus_error`  out  1: qualified by `rsp_valid_miss`.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o`  out  1 each: Wishbone master controls.
- `wbm_sel_o`  out  4: always `4'hF` while `stb` is high, else 0.
- `wbm_adr_o`  out  32: byte address.
- `wbm_dat_o`  out  32: write word.
- `wbm_ack_i`, `wbm_err_i`  in  1 each: slave terminations.
- `wbm_dat_i`  in  32: read word.
- `busy_o`  out  1: high whenever the FSM is not in IDLE.

## Operation
- **Pending slots.** Each cache has one pending slot (valid flag plus 149-bit info), captured on its miss strobe.
  - A strobe arriving while that cache's slot is already valid is ignored; the held request is kept.
  - Both strobes in the same cycle capture both slots.
- **FSM states: IDLE, BUS, RESP.**
  - IDLE → BUS when any slot is valid. The dcache slot wins if both are valid. The granted slot is copied into working registers and its valid flag is cleared.
  - BUS: `cyc`/`stb` are high, beat counter `b` runs 0..3.
    - `wbm_adr_o = WB_BASE_ADDR + {line_addr, 4'b0} + 4*b`.
    - `wbm_we_o = info[128]`.
    - `wbm_dat_o = data[32b+31:32b]`.
  - On ack in beat `b`: a read stores `wbm_dat_i` into word `b`. If `b` < 3, increment `b`; if `b` = 3, go to RESP.
  - On err in any beat (err wins over a simultaneous ack): go to RESP with error = 1 and the data register cleared.
  - RESP: for one cycle, `cyc`/`stb` are low and `rsp_valid_miss` = 1 with `rsp_cache_id`, `rsp_bus_error`, `rsp_data_miss`. Then return to IDLE.
- **Strobes during BUS.** A miss strobe from the cache not being serviced is captured into its slot during BUS and is serviced after RESP.
- **Address arithmetic.** All address arithmetic is 32-bit modulo; wrap past `32'hFFFF_FFFF` is not checked.
- **Ignored inputs.** `ack`/`err` received while `stb` is low are ignored.

## Timing
- **Reset values.** While `reset_ni` = 0:
  - All outputs are 0, except `wbm_sel_o` = 0.
  - The FSM is in IDLE, both slots are invalid, and `b` = 0.
  - Reset takes effect immediately, including mid-burst; the in-flight transaction and pending slots are dropped without a response.
- **Capture to bus.** A miss captured at edge N puts `cyc`/`stb` high in cycle N+1.
- **Beat handshake.** Ack is sampled at the clock edge. The next beat's address/data appear in the cycle after an ack, and `stb` stays high between beats.
- **Zero-wait latency.** With a zero-wait slave (ack in every `stb` cycle), beats occupy cycles N+1..N+4 and `rsp_valid_miss` is high in cycle N+5: 5 cycles from miss strobe to response.
- **Back-to-back requests.** A queued request starts in the cycle after RESP, so at least one idle cycle separates bursts.

## Configuration
- **`WB_MISS_TIMEOUT_EN` defined:** a per-beat counter resets on every beat start and on every ack.
  - If `TIMEOUT_CYCLES` cycles pass without ack/err, the block behaves exactly as for `wbm_err_i`: RESP with `rsp_bus_error` = 1.
- **`WB_MISS_TIMEOUT_EN` undefined:** no counter exists and the block waits for ack/err indefinitely.

## Structure
- **Shared package `core_mem_pkg`** holds:
  - `MISS_INFO_W` = 149, `LINE_W` = 128, `LINE_ADDR_W` = 20.
  - Field offsets: `MISS_ADDR_MSB` = 148, `MISS_WE_BIT` = 128.
  - `miss_info_t` packed struct.
  - FSM state enum.
- **Sub-module `core_wb_miss_arb`:** the two pending slots plus the fixed-priority grant. It outputs grant valid, grant id and grant info, and takes a pop input.

## Test plan
- **dcache read, zero-wait slave returning `32'h11`, `32'h22`, `32'h33`, `32'h44`, line address `20'h5`:**
  - Addresses `3000_0050`, `…54`, `…58`, `…5C`.
  - Response at N+5 with data `128'h00000044_00000033_00000022_00000011`, id = 1, error = 0.
- **Simultaneous icache and dcache miss strobes:** the dcache burst runs first, then the icache burst; there are two responses with id 1 then 0, and one idle cycle between bursts.
- **icache write with a slave inserting 2 wait states per beat:**
  - `we` = 1 and `wbm_dat_o` follows the line words in order.
  - `stb` is held through the waits.
  - The response arrives 13 cycles after the strobe with data 0.
- **`wbm_err_i` on beat 2 of a read:** `cyc` drops the next cycle, and the response has error = 1 and data 0.
- **Timeout:** with `WB_MISS_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 16, a slave that never acks produces a response with error = 1 exactly 16 cycles after the beat start. Without the macro, `cyc` stays high indefinitely.
- **`reset_ni` low in the middle of beat 1:** all outputs go to 0 immediately, and no response follows after release.

Source files
------------

// File: rtl/core_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : core_mem_pkg
// Purpose : Shared widths, miss-request field layout and the Wishbone miss
//           master FSM state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package core_mem_pkg;

    localparam int MISS_INFO_W   = 149;
    localparam int LINE_W        = 128;
    localparam int LINE_ADDR_W   = 20;
    localparam int MISS_ADDR_MSB = 148;
    localparam int MISS_WE_BIT   = 128;

    // Field order matches the flat request bus: [148:129] addr, [128] we, [127:0] data.
    typedef struct packed {
        logic [LINE_ADDR_W-1:0] line_addr;
        logic                   we;
        logic [LINE_W-1:0]      data;
    } miss_info_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } miss_state_e;

endpackage : core_mem_pkg
`default_nettype wire

// File: rtl/core_wb_miss_arb.sv
`default_nettype none
// ============================================================================
// Module  : core_wb_miss_arb
// Purpose : One pending miss slot per cache plus fixed dcache-first grant.
//           A strobe arriving in the grant cycle is granted directly, so a
//           miss reaches the bus one cycle after its strobe.
// Revision: 1.0 - initial release
// ============================================================================
module core_wb_miss_arb
    import core_mem_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic                   i_dcache_valid,
    input  logic [MISS_INFO_W-1:0] i_dcache_info,
    input  logic                   i_icache_valid,
    input  logic [MISS_INFO_W-1:0] i_icache_info,
    input  logic                   i_pop,
    output logic                   o_grant_valid,
    output logic                   o_grant_id,
    output logic [MISS_INFO_W-1:0] o_grant_info
);

    logic                   r_d_valid;
    logic                   r_i_valid;
    logic [MISS_INFO_W-1:0] r_d_info;
    logic [MISS_INFO_W-1:0] r_i_info;
    logic                   w_d_avail;
    logic                   w_i_avail;

    assign w_d_avail     = r_d_valid | i_dcache_valid;
    assign w_i_avail     = r_i_valid | i_icache_valid;
    assign o_grant_valid = w_d_avail | w_i_avail;
    assign o_grant_id    = w_d_avail;
    assign o_grant_info  = w_d_avail ? (r_d_valid ? r_d_info : i_dcache_info)
                                     : (r_i_valid ? r_i_info : i_icache_info);

    // Slot update: a pop retires the granted request; otherwise a strobe fills an empty slot.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_d_valid <= 1'b0;
            r_i_valid <= 1'b0;
            r_d_info  <= '0;
            r_i_info  <= '0;
        end else begin
            if (i_pop && w_d_avail) begin
                r_d_valid <= 1'b0;
            end else if (i_dcache_valid && !r_d_valid) begin
                r_d_valid <= 1'b1;
                r_d_info  <= i_dcache_info;
            end
            if (i_pop && !w_d_avail) begin
                r_i_valid <= 1'b0;
            end else if (i_icache_valid && !r_i_valid) begin
                r_i_valid <= 1'b1;
                r_i_info  <= i_icache_info;
            end
        end
    end

endmodule : core_wb_miss_arb
`default_nettype wire

// File: rtl/core_wb_miss_master.sv
`default_nettype none
// ============================================================================
// Module  : core_wb_miss_master
// Purpose : Wishbone initiator servicing icache/dcache line misses as four
//           single-word transfers per 128-bit line, with a one-cycle
//           response strobe back to the caches.
// Config  : WB_MISS_TIMEOUT_EN - per-beat ack/err watchdog (TIMEOUT_CYCLES).
// Revision: 1.0 - initial release
// ============================================================================
module core_wb_miss_master
    import core_mem_pkg::*;
#(
    parameter logic [31:0] WB_BASE_ADDR   = 32'h3000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic                   dcache_req_valid_miss,
    input  logic [MISS_INFO_W-1:0] dcache_req_info_miss,
    input  logic                   icache_req_valid_miss,
    input  logic [MISS_INFO_W-1:0] icache_req_info_miss,
    output logic                   rsp_valid_miss,
    output logic [LINE_W-1:0]      rsp_data_miss,
    output logic                   rsp_cache_id,
    output logic                   rsp_bus_error,
    output logic                   wbm_cyc_o,
    output logic                   wbm_stb_o,
    output logic                   wbm_we_o,
    output logic [3:0]             wbm_sel_o,
    output logic [31:0]            wbm_adr_o,
    output logic [31:0]            wbm_dat_o,
    input  logic                   wbm_ack_i,
    input  logic                   wbm_err_i,
    input  logic [31:0]            wbm_dat_i,
    output logic                   busy_o
);

    miss_state_e            r_state;
    miss_state_e            w_state_nxt;
    logic [1:0]             r_beat;
    logic                   r_id;
    logic                   r_we;
    logic                   r_err;
    logic [LINE_ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0]      r_data;
    logic                   w_pop;
    logic                   w_grant_valid;
    logic                   w_grant_id;
    logic [MISS_INFO_W-1:0] w_grant_info;
    miss_info_t             w_grant;
    logic                   w_timeout;
    logic                   w_bus_err;
    logic                   w_in_bus;
    logic                   w_in_resp;

    core_wb_miss_arb u_arb (
        .clk_i          (clk_i),
        .reset_ni       (reset_ni),
        .i_dcache_valid (dcache_req_valid_miss),
        .i_dcache_info  (dcache_req_info_miss),
        .i_icache_valid (icache_req_valid_miss),
        .i_icache_info  (icache_req_info_miss),
        .i_pop          (w_pop),
        .o_grant_valid  (w_grant_valid),
        .o_grant_id     (w_grant_id),
        .o_grant_info   (w_grant_info)
    );

    assign w_grant   = w_grant_info;
    assign w_in_bus  = (r_state == ST_BUS);
    assign w_in_resp = (r_state == ST_RESP);
    assign w_bus_err = wbm_err_i | w_timeout;

`ifdef WB_MISS_TIMEOUT_EN
    localparam int C_TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [C_TMO_W-1:0] r_tmo_cnt;

    // Watchdog: restarts at every beat start and every ack, counts while a beat is pending.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_tmo_cnt <= '0;
        end else if (!w_in_bus || wbm_ack_i) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign w_timeout = w_in_bus && !wbm_ack_i &&
                       (r_tmo_cnt == C_TMO_W'(TIMEOUT_CYCLES - 1));
`else
    // No watchdog in this build; the expression is constant 0.
    assign w_timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    // State register.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, grant pop and all bus/response outputs (gated so idle drives zeros).
    always_comb begin
        w_state_nxt    = r_state;
        w_pop          = 1'b0;
        wbm_cyc_o      = w_in_bus;
        wbm_stb_o      = w_in_bus;
        wbm_we_o       = w_in_bus & r_we;
        wbm_sel_o      = w_in_bus ? 4'hF : 4'h0;
        wbm_adr_o      = w_in_bus ? (WB_BASE_ADDR + {8'd0, r_addr, 4'd0} + {28'd0, r_beat, 2'd0})
                                  : 32'd0;
        wbm_dat_o      = w_in_bus ? r_data[{r_beat, 5'd0} +: 32] : 32'd0;
        rsp_valid_miss = w_in_resp;
        rsp_cache_id   = w_in_resp & r_id;
        rsp_bus_error  = w_in_resp & r_err;
        rsp_data_miss  = (w_in_resp && !r_we) ? r_data : '0;
        busy_o         = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (w_grant_valid) begin
                    w_state_nxt = ST_BUS;
                    w_pop       = 1'b1;
                end
            end
            ST_BUS: begin
                if (w_bus_err || (wbm_ack_i && (r_beat == 2'd3))) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Working registers: load on grant, collect read words per ack, clear line on error.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_beat <= 2'd0;
            r_id   <= 1'b0;
            r_we   <= 1'b0;
            r_err  <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_beat <= 2'd0;
                        r_id   <= w_grant_id;
                        r_we   <= w_grant.we;
                        r_err  <= 1'b0;
                        r_addr <= w_grant.line_addr;
                        r_data <= w_grant.data;
                    end
                end
                ST_BUS: begin
                    if (w_bus_err) begin
                        r_err  <= 1'b1;
                        r_data <= '0;
                    end else if (wbm_ack_i) begin
                        if (!r_we) begin
                            r_data[{r_beat, 5'd0} +: 32] <= wbm_dat_i;
                        end
                        r_beat <= r_beat + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : core_wb_miss_master
`default_nettype wire

// File: tb/tb_core_wb_miss_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_core_wb_miss_master
// Purpose : Self-checking bench: directed vector table, hand-written corner
//           sequences and randomized transactions against a line-level model.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_core_wb_miss_master;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic         clk_i = 1'b0;
    logic         reset_ni;
    logic         dcache_req_valid_miss, icache_req_valid_miss;
    logic [148:0] dcache_req_info_miss, icache_req_info_miss;
    logic         rsp_valid_miss, rsp_cache_id, rsp_bus_error;
    logic [127:0] rsp_data_miss;
    logic         wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i, wbm_err_i, busy_o;
    logic [3:0]   wbm_sel_o;
    logic [31:0]  wbm_adr_o, wbm_dat_o, wbm_dat_i;

    always #5 clk_i = ~clk_i;

    core_wb_miss_master #(.WB_BASE_ADDR(BASE), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .dcache_req_valid_miss(dcache_req_valid_miss), .dcache_req_info_miss(dcache_req_info_miss),
        .icache_req_valid_miss(icache_req_valid_miss), .icache_req_info_miss(icache_req_info_miss),
        .rsp_valid_miss(rsp_valid_miss), .rsp_data_miss(rsp_data_miss),
        .rsp_cache_id(rsp_cache_id), .rsp_bus_error(rsp_bus_error),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_dat_i(wbm_dat_i),
        .busy_o(busy_o)
    );

    typedef struct { int t; logic [31:0] adr; logic we; logic [31:0] dat; logic [3:0] sel; } beat_t;
    typedef struct { int t; logic id; logic err; logic [127:0] data; } rsp_t;
    typedef struct { int t; logic id; logic [148:0] info; } evt_t;
    typedef struct {
        logic id; logic we; logic [19:0] line; logic [127:0] data; int ws; int eb;
        logic [127:0] rd; int exp_t; logic [127:0] exp_data; logic exp_err;
    } vec_t;

    beat_t beats[$];
    rsp_t  rsps[$];
    int    starts[$];
    evt_t  evts[$];
    int    n_checks = 0, n_fail = 0;
    int    slv_ws, slv_eb, slv_wcnt, slv_beat, stb_cycles;
    logic [127:0] slv_rd;
    bit    slv_noise, prev_cyc, cyc_stb_ok;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [148:0] mk(input logic [19:0] la, input logic we, input logic [127:0] d);
        return {la, we, d};
    endfunction

    function automatic logic [31:0] exp_adr(input logic [19:0] la, input int k);
        return BASE + 32'(la) * 32'd16 + 32'(k) * 32'd4;
    endfunction

    task automatic scn_begin(input int ws, input int eb, input logic [127:0] rd, input bit noise);
        beats.delete(); rsps.delete(); starts.delete(); evts.delete();
        slv_ws = ws; slv_eb = eb; slv_rd = rd; slv_noise = noise;
        slv_wcnt = 0; slv_beat = 0; stb_cycles = 0;
        prev_cyc = wbm_cyc_o; cyc_stb_ok = 1'b1;
    endtask

    task automatic sched(input int t, input logic id, input logic [148:0] info);
        evts.push_back('{t, id, info});
    endtask

    // Cycle t is the cycle after the t-th edge; strobes scheduled at t are high during it.
    task automatic run(input int ncyc);
        for (int t = 0; t <= ncyc; t++) begin
            if (t > 0) begin @(posedge clk_i); #1; end
            dcache_req_valid_miss = 1'b0;
            icache_req_valid_miss = 1'b0;
            foreach (evts[i]) if (evts[i].t == t) begin
                if (evts[i].id) begin dcache_req_valid_miss = 1'b1; dcache_req_info_miss = evts[i].info; end
                else            begin icache_req_valid_miss = 1'b1; icache_req_info_miss = evts[i].info; end
            end
            if (rsp_valid_miss) rsps.push_back('{t, rsp_cache_id, rsp_bus_error, rsp_data_miss});
            if (wbm_cyc_o && !prev_cyc) starts.push_back(t);
            if (wbm_cyc_o !== wbm_stb_o) cyc_stb_ok = 1'b0;
            prev_cyc  = wbm_cyc_o;
            wbm_ack_i = 1'b0;
            wbm_err_i = 1'b0;
            wbm_dat_i = $urandom;
            if (wbm_stb_o) begin
                stb_cycles++;
                if (slv_wcnt < slv_ws) slv_wcnt++;
                else begin
                    slv_wcnt = 0;
                    beats.push_back('{t, wbm_adr_o, wbm_we_o, wbm_dat_o, wbm_sel_o});
                    if (slv_beat == slv_eb) wbm_err_i = 1'b1;
                    else begin wbm_ack_i = 1'b1; wbm_dat_i = slv_rd[32*slv_beat +: 32]; end
                    slv_beat++;
                end
            end else begin
                slv_wcnt = 0;
                slv_beat = 0;
                if (slv_noise) begin
                    wbm_ack_i = 1'($urandom_range(0, 1));
                    wbm_err_i = 1'($urandom_range(0, 1));
                end
            end
        end
        dcache_req_valid_miss = 1'b0;
        icache_req_valid_miss = 1'b0;
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
    endtask

    task automatic check_beats(input string tag, input int base, input logic [19:0] la, input logic we,
                               input logic [127:0] d, input int ws, input int eb, input int t0);
        int nb;
        nb = (eb >= 0) ? eb + 1 : 4;
        if (beats.size() < base + nb) begin
            n_checks++; n_fail++;
            $display("FAIL %s_nbeats: got %0d, expected %0d", tag, beats.size(), base + nb);
            return;
        end
        for (int k = 0; k < nb; k++) begin
            check({tag, "_adr"}, beats[base+k].adr, exp_adr(la, k));
            check({tag, "_beat_t"}, beats[base+k].t, t0 + k * (ws + 1) + ws);
            check({tag, "_we_sel"}, {beats[base+k].we, beats[base+k].sel}, {we, 4'hF});
            if (we) check({tag, "_wdat"}, beats[base+k].dat, d[32*k +: 32]);
        end
    endtask

    task automatic check_rsp(input string tag, input int idx, input int t, input logic id,
                             input logic err, input logic [127:0] data);
        if (rsps.size() <= idx) begin
            n_checks++; n_fail++;
            $display("FAIL %s_rsp_missing: got %0d responses, expected more than %0d", tag, rsps.size(), idx);
            return;
        end
        check({tag, "_rsp_t"}, rsps[idx].t, t);
        check({tag, "_rsp_id_err"}, {rsps[idx].id, rsps[idx].err}, {id, err});
        check({tag, "_rsp_data"}, rsps[idx].data, data);
    endtask

    // One isolated transaction: strobe at t=0, burst from t=1, response and shape checked.
    task automatic do_txn(input string tag, input logic id, input logic we, input logic [19:0] la,
                          input logic [127:0] d, input int ws, input int eb, input logic [127:0] rd,
                          input bit noise, input int exp_t, input logic [127:0] exp_data, input logic exp_err);
        int nb;
        nb = (eb >= 0) ? eb + 1 : 4;
        scn_begin(ws, eb, rd, noise);
        sched(0, id, mk(la, we, d));
        run(exp_t + 3);
        check({tag, "_nrsp"}, rsps.size(), 1);
        check_rsp(tag, 0, exp_t, id, exp_err, exp_data);
        check({tag, "_start"}, (starts.size() > 0) ? starts[0] : -1, 1);
        check({tag, "_stb_cycles"}, stb_cycles, nb * (ws + 1));
        check({tag, "_cyc_eq_stb"}, cyc_stb_ok, 1);
        check_beats(tag, 0, la, we, d, ws, eb, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rsp"}, {rsp_valid_miss, rsp_cache_id, rsp_bus_error}, 3'b000);
        check({tag, "_rsp_data"}, rsp_data_miss, 128'd0);
        check({tag, "_wb"}, {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, busy_o}, 72'd0);
    endtask

    vec_t vecs[6];

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 20'h00005, 128'd0, 0, -1, 128'h00000044_00000033_00000022_00000011,
                    5, 128'h00000044_00000033_00000022_00000011, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 20'hABCDE, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 2, -1, 128'd0,
                    13, 128'd0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 20'h00010, 128'd0, 0, 2, 128'h55555555_66666666_77777777_88888888,
                    4, 128'd0, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 20'hFFFFF, 128'd0, 1, -1, 128'h01234567_89ABCDEF_FEDCBA98_76543210,
                    9, 128'h01234567_89ABCDEF_FEDCBA98_76543210, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 20'h00000, 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0, 3, 0, 128'd0,
                    5, 128'd0, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 20'h12345, 128'd0, 0, 3, 128'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC,
                    5, 128'd0, 1'b1};

        reset_ni = 1'b0;
        dcache_req_valid_miss = 1'b0; icache_req_valid_miss = 1'b0;
        dcache_req_info_miss = '0; icache_req_info_miss = '0;
        wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_dat_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check_reset_outputs("reset");
        reset_ni = 1'b1;
        @(posedge clk_i); #1;

        // Directed vector table.
        foreach (vecs[i])
            do_txn($sformatf("vec%0d", i), vecs[i].id, vecs[i].we, vecs[i].line, vecs[i].data,
                   vecs[i].ws, vecs[i].eb, vecs[i].rd, 1'b0, vecs[i].exp_t, vecs[i].exp_data, vecs[i].exp_err);

        // Simultaneous strobes: dcache first, icache after RESP and one idle cycle.
        scn_begin(0, -1, 128'h4_00000003_00000002_00000001, 1'b0);
        sched(0, 1'b1, mk(20'h00100, 1'b0, '0));
        sched(0, 1'b0, mk(20'h00200, 1'b0, '0));
        run(16);
        check("simul_nrsp", rsps.size(), 2);
        check_rsp("simul0", 0, 5, 1'b1, 1'b0, 128'h4_00000003_00000002_00000001);
        check_rsp("simul1", 1, 11, 1'b0, 1'b0, 128'h4_00000003_00000002_00000001);
        check("simul_starts", {(starts.size() > 1) ? starts[1] : -1}, 7);
        check_beats("simul_d", 0, 20'h00100, 1'b0, '0, 0, -1, 1);
        check_beats("simul_i", 4, 20'h00200, 1'b0, '0, 0, -1, 7);

        // Full dcache slot ignores a second strobe; icache strobe during BUS waits its turn.
        scn_begin(0, -1, 128'd0, 1'b0);
        sched(0, 1'b1, mk(20'h00001, 1'b1, 128'h1111_2222_3333_4444_5555_6666_7777_8888));
        sched(1, 1'b1, mk(20'h00002, 1'b0, '0));
        sched(2, 1'b1, mk(20'h00003, 1'b0, '0));
        sched(2, 1'b0, mk(20'h00007, 1'b0, '0));
        run(24);
        check("hold_nrsp", rsps.size(), 3);
        check("hold_nbeats", beats.size(), 12);
        check_rsp("hold0", 0, 5, 1'b1, 1'b0, 128'd0);
        check_rsp("hold1", 1, 11, 1'b1, 1'b0, 128'd0);
        check_rsp("hold2", 2, 17, 1'b0, 1'b0, 128'd0);
        check_beats("hold_d1", 0, 20'h00001, 1'b1, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 0, -1, 1);
        check_beats("hold_d2", 4, 20'h00002, 1'b0, '0, 0, -1, 7);
        check_beats("hold_i7", 8, 20'h00007, 1'b0, '0, 0, -1, 13);

        // Slave that never terminates.
        scn_begin(100000, -1, 128'd0, 1'b0);
        sched(0, 1'b1, mk(20'h00009, 1'b0, '0));
        run(40);
`ifdef WB_MISS_TIMEOUT_EN
        check("tmo_nrsp", rsps.size(), 1);
        check_rsp("tmo", 0, 17, 1'b1, 1'b1, 128'd0);
        check("tmo_cyc_end", wbm_cyc_o, 1'b0);
`else
        check("noack_nrsp", rsps.size(), 0);
        check("noack_cyc_held", {wbm_cyc_o, wbm_stb_o}, 2'b11);
`endif
        reset_ni = 1'b0;
        #1;
        check_reset_outputs("noack_reset");
        @(posedge clk_i); #1;
        reset_ni = 1'b1;

        // Reset in the middle of beat 1 with an icache miss also pending.
        scn_begin(0, -1, 128'd0, 1'b0);
        sched(0, 1'b1, mk(20'h00033, 1'b0, '0));
        sched(1, 1'b0, mk(20'h00044, 1'b0, '0));
        run(2);
        check("midrst_in_beat1", {wbm_cyc_o, wbm_adr_o}, {1'b1, exp_adr(20'h00033, 1)});
        reset_ni = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk_i); @(posedge clk_i); #1;
        reset_ni = 1'b1;
        scn_begin(0, -1, 128'd0, 1'b0);
        run(20);
        check("midrst_no_rsp", rsps.size(), 0);
        check("midrst_no_burst", starts.size(), 0);

        // Randomized single transactions against the line-level model.
        for (int n = 0; n < 30; n++) begin
            logic id, we, eerr;
            logic [19:0] la;
            logic [127:0] d, rd, edata;
            int ws, eb, nb, et;
            id = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            la = 20'($urandom);
            d  = {$urandom, $urandom, $urandom, $urandom};
            rd = {$urandom, $urandom, $urandom, $urandom};
            ws = $urandom_range(0, 3);
            eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
            nb = (eb >= 0) ? eb + 1 : 4;
            et = 1 + nb * (ws + 1);
            eerr  = (eb >= 0);
            edata = (eerr || we) ? 128'd0 : rd;
            do_txn($sformatf("rand%0d", n), id, we, la, d, ws, eb, rd, 1'b1, et, edata, eerr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
